// File: rtl/sr_flag_arbiter_if.sv
// Command/status bundle between NREQ requesters and the shared SR flag bank.
// err/err_req exist only when SR_FLAG_ERR_EN is defined.
interface sr_flag_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int NFLAGS = 8,
    parameter int IDXW   = $clog2(NFLAGS),
    parameter int REQW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      cmd_s;
    logic [NREQ-1:0]      cmd_r;
    logic [NREQ*IDXW-1:0] cmd_idx;
    logic [NREQ-1:0]      ack;
    logic [NFLAGS-1:0]    flags;
    logic [NFLAGS-1:0]    flags_b;
    logic                 busy;
`ifdef SR_FLAG_ERR_EN
    logic                 err;
    logic [REQW-1:0]      err_req;
`endif

    modport master (
        output req, cmd_s, cmd_r, cmd_idx,
        input  ack, flags, flags_b, busy
`ifdef SR_FLAG_ERR_EN
        , input err, err_req
`endif
    );

    modport slave (
        input  req, cmd_s, cmd_r, cmd_idx,
        output ack, flags, flags_b, busy
`ifdef SR_FLAG_ERR_EN
        , output err, err_req
`endif
    );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Rotating-priority arbiter applying set/reset commands to a shared flag bank.
// Optional SR_FLAG_ERR_EN adds a sticky error for s=r=1 commands.
//   state    | meaning
//   ST_IDLE  | searching req from ptr, latching winner's command
//   ST_APPLY | ack winner, write flag bank at closing edge
module sr_flag_arbiter #(
    parameter int NREQ   = 4,
    parameter int NFLAGS = 8,
    parameter int IDXW   = $clog2(NFLAGS)
) (
    input  logic               clk_i,
    input  logic               clear_i,
    sr_flag_arbiter_if.slave   bus
);
    localparam int REQW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ST_IDLE, ST_APPLY} state_e;

    state_e            state_q, state_d;
    logic [REQW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              s_q, s_d, r_q, r_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [NFLAGS-1:0] flags_q, flags_d;
`ifdef SR_FLAG_ERR_EN
    logic [REQW-1:0]   gnt_id_q, gnt_id_d;
    logic              err_q, err_d;
    logic [REQW-1:0]   err_req_q, err_req_d;
`endif

    logic              sel_found;
    logic [REQW-1:0]   sel_id;
    int                cand;

    // Walk downward so the candidate closest to ptr is the last one written.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        cand      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = (int'(ptr_q) + k) % NREQ;
            if (bus.req[cand]) begin
                sel_found = 1'b1;
                sel_id    = REQW'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        s_d     = s_q;
        r_d     = r_q;
        idx_d   = idx_q;
        flags_d = flags_q;
`ifdef SR_FLAG_ERR_EN
        gnt_id_d  = gnt_id_q;
        err_d     = err_q;
        err_req_d = err_req_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d        = ST_APPLY;
                    ptr_d          = (int'(sel_id) == NREQ - 1) ? '0 : sel_id + 1'b1;
                    gnt_d          = '0;
                    gnt_d[sel_id]  = 1'b1;
                    s_d            = bus.cmd_s[sel_id];
                    r_d            = bus.cmd_r[sel_id];
                    idx_d          = bus.cmd_idx[int'(sel_id)*IDXW +: IDXW];
`ifdef SR_FLAG_ERR_EN
                    gnt_id_d       = sel_id;
`endif
                end
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
                if (int'(idx_q) < NFLAGS) begin
                    case ({s_q, r_q})
                        2'b10:   flags_d[idx_q] = 1'b1;
                        2'b01:   flags_d[idx_q] = 1'b0;
                        default: ;
                    endcase
                end
`ifdef SR_FLAG_ERR_EN
                if (s_q && r_q && !err_q) begin
                    err_d     = 1'b1;
                    err_req_d = gnt_id_q;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            idx_q   <= '0;
            flags_q <= '0;
`ifdef SR_FLAG_ERR_EN
            gnt_id_q  <= '0;
            err_q     <= 1'b0;
            err_req_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            flags_q <= flags_d;
`ifdef SR_FLAG_ERR_EN
            gnt_id_q  <= gnt_id_d;
            err_q     <= err_d;
            err_req_q <= err_req_d;
`endif
        end
    end

    // A clear landing on the APPLY cycle drops the command, so suppress its ack.
    assign bus.ack     = (state_q == ST_APPLY && !clear_i) ? gnt_q : '0;
    assign bus.busy    = (state_q == ST_APPLY) && !clear_i;
    assign bus.flags   = flags_q;
    assign bus.flags_b = ~flags_q;
`ifdef SR_FLAG_ERR_EN
    assign bus.err     = err_q;
    assign bus.err_req = err_req_q;
`endif
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Self-checking bench for sr_flag_arbiter: directed scenarios plus randomized
// traffic against a transaction-level flag/priority model.
module tb_sr_flag_arbiter;
    localparam int NREQ   = 4;
    localparam int NFLAGS = 8;
    localparam int IDXW   = 3;

    logic clk = 1'b0;
    logic clear;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sr_flag_arbiter_if #(.NREQ(NREQ), .NFLAGS(NFLAGS)) bus ();

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAGS(NFLAGS)) dut (
        .clk_i   (clk),
        .clear_i (clear),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit s, input bit r, input int idx);
        bus.req[i]                 = 1'b1;
        bus.cmd_s[i]               = s;
        bus.cmd_r[i]               = r;
        bus.cmd_idx[i*IDXW +: IDXW] = IDXW'(idx);
    endtask

    task automatic do_clear();
        clear   = 1'b1;
        bus.req = '0;
        tick();
        clear   = 1'b0;
    endtask

    // Issue one command from requester g alone and wait (bounded) for its ack.
    task automatic issue(input int g, input bit s, input bit r, input int idx);
        int waited = 0;
        set_req(g, s, r, idx);
        do begin
            tick();
            waited++;
        end while (bus.ack[g] !== 1'b1 && waited < 5);
        n_checks++;
        if (bus.ack[g] !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ack req=%0d: ack=%b after %0d cycles", g, bus.ack, waited);
        end
        bus.req[g] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, i);
        clear = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (bus.flags !== 8'h00 || bus.ack !== 4'b0000 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state cyc=%0d: flags=%h ack=%b busy=%b, want 00/0000/0",
                         c, bus.flags, bus.ack, bus.busy);
            end
        end
        clear = 1'b0;
        tick();
        n_checks++;
        if (bus.ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: ack=%b want 0001", bus.ack);
        end
        bus.req = '0;
        tick();
        n_checks++;
        if (bus.flags !== 8'h01) begin
            n_fail++;
            $display("FAIL reset_first_apply: flags=%h want 01", bus.flags);
        end
    endtask

    task automatic test_single();
        do_clear();
        set_req(1, 1'b1, 1'b0, 5);
        tick();
        n_checks++;
        if (bus.ack !== 4'b0010 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ack: ack=%b busy=%b want 0010/1", bus.ack, bus.busy);
        end
        bus.req[1] = 1'b0;
        tick();
        n_checks++;
        if (bus.ack !== 4'b0000 || bus.busy !== 1'b0 || bus.flags !== 8'h20 || bus.flags_b !== 8'hDF) begin
            n_fail++;
            $display("FAIL single_apply: ack=%b busy=%b flags=%h flags_b=%h want 0000/0/20/df",
                     bus.ack, bus.busy, bus.flags, bus.flags_b);
        end
    endtask

    task automatic test_three();
        logic [3:0] exp_ack [7];
        exp_ack = '{4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
        do_clear();
        set_req(0, 1'b1, 1'b0, 0);
        set_req(2, 1'b1, 1'b0, 2);
        set_req(3, 1'b1, 1'b0, 3);
        for (int c = 1; c < 7; c++) begin
            tick();
            n_checks++;
            if (bus.ack !== exp_ack[c]) begin
                n_fail++;
                $display("FAIL three_order cyc=T+%0d: ack=%b want %b", c, bus.ack, exp_ack[c]);
            end
            bus.req = bus.req & ~bus.ack;
        end
        n_checks++;
        if (bus.flags !== 8'h0D) begin
            n_fail++;
            $display("FAIL three_flags: flags=%h want 0d", bus.flags);
        end
    endtask

    task automatic test_same_idx();
        do_clear();
        // Grants 3,0,1,2,3,0,1,2 leave the pointer at 3.
        for (int k = 0; k < 8; k++) issue((k + 3) % NREQ, 1'b1, 1'b0, k);
        n_checks++;
        if (bus.flags !== 8'hFF) begin
            n_fail++;
            $display("FAIL same_idx_setup: flags=%h want ff", bus.flags);
        end
        set_req(3, 1'b0, 1'b1, 0);
        set_req(0, 1'b1, 1'b0, 0);
        tick();
        n_checks++;
        if (bus.ack !== 4'b1000) begin
            n_fail++;
            $display("FAIL same_idx_first: ack=%b want 1000", bus.ack);
        end
        bus.req[3] = 1'b0;
        tick();
        n_checks++;
        if (bus.flags !== 8'hFE) begin
            n_fail++;
            $display("FAIL same_idx_mid: flags=%h want fe", bus.flags);
        end
        tick();
        n_checks++;
        if (bus.ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL same_idx_second: ack=%b want 0001", bus.ack);
        end
        bus.req[0] = 1'b0;
        tick();
        n_checks++;
        if (bus.flags !== 8'hFF) begin
            n_fail++;
            $display("FAIL same_idx_final: flags=%h want ff", bus.flags);
        end
    endtask

    task automatic test_both();
        do_clear();
        set_req(2, 1'b1, 1'b1, 3);
        tick();
        n_checks++;
        if (bus.ack !== 4'b0100) begin
            n_fail++;
            $display("FAIL both_ack: ack=%b want 0100", bus.ack);
        end
        bus.req[2] = 1'b0;
        tick();
        n_checks++;
        if (bus.flags !== 8'h00) begin
            n_fail++;
            $display("FAIL both_flags: flags=%h want 00", bus.flags);
        end
`ifdef SR_FLAG_ERR_EN
        n_checks++;
        if (bus.err !== 1'b1 || bus.err_req !== 2'd2) begin
            n_fail++;
            $display("FAIL both_err: err=%b err_req=%0d want 1/2", bus.err, bus.err_req);
        end
`endif
        issue(1, 1'b1, 1'b1, 4);
        n_checks++;
        if (bus.flags !== 8'h00) begin
            n_fail++;
            $display("FAIL both_second_flags: flags=%h want 00", bus.flags);
        end
`ifdef SR_FLAG_ERR_EN
        n_checks++;
        if (bus.err !== 1'b1 || bus.err_req !== 2'd2) begin
            n_fail++;
            $display("FAIL both_err_sticky: err=%b err_req=%0d want 1/2", bus.err, bus.err_req);
        end
`endif
    endtask

    task automatic test_clear_apply();
        do_clear();
        set_req(0, 1'b1, 1'b0, 1);
        tick();
        clear   = 1'b1;
        bus.req = '0;
        #1;
        n_checks++;
        if (bus.ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL clear_apply_ack: ack=%b want 0000", bus.ack);
        end
        tick();
        clear = 1'b0;
        n_checks++;
        if (bus.flags !== 8'h00 || bus.busy !== 1'b0 || bus.ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL clear_apply_after: flags=%h busy=%b ack=%b want 00/0/0000",
                     bus.flags, bus.busy, bus.ack);
        end
        issue(0, 1'b1, 1'b0, 1);
        n_checks++;
        if (bus.flags !== 8'h02) begin
            n_fail++;
            $display("FAIL clear_apply_reissue: flags=%h want 02", bus.flags);
        end
    endtask

    // Random bursts: each burst raises a random set of requesters and serves them all.
    task automatic test_random();
        logic [NFLAGS-1:0] mflags;
        int                mptr;
        logic [NREQ-1:0]   pend;
        bit                ms [NREQ];
        bit                mr [NREQ];
        int                midx [NREQ];
        int                g;
        int                c;
        int                waited;
        logic [NREQ-1:0]   exp_ack;
`ifdef SR_FLAG_ERR_EN
        bit                merr;
        int                merr_req;
        merr     = 1'b0;
        merr_req = 0;
`endif
        do_clear();
        mflags = '0;
        mptr   = 0;
        for (int round = 0; round < 40; round++) begin
            pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i]) begin
                    ms[i]   = 1'($urandom_range(0, 1));
                    mr[i]   = 1'($urandom_range(0, 1));
                    midx[i] = $urandom_range(0, NFLAGS - 1);
                    set_req(i, ms[i], mr[i], midx[i]);
                end
            end
            while (pend != '0) begin
                waited = 0;
                do begin
                    tick();
                    waited++;
                end while (bus.ack === '0 && waited < 4);
                g = -1;
                for (int k = 0; k < NREQ; k++) begin
                    c = (mptr + k) % NREQ;
                    if (pend[c] && g < 0) g = c;
                end
                exp_ack    = '0;
                exp_ack[g] = 1'b1;
                n_checks++;
                if (bus.ack !== exp_ack || waited != 1 || bus.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_grant round=%0d: ack=%b busy=%b wait=%0d want %b/1/1",
                             round, bus.ack, bus.busy, waited, exp_ack);
                end
                if (ms[g] && !mr[g]) mflags[midx[g]] = 1'b1;
                else if (!ms[g] && mr[g]) mflags[midx[g]] = 1'b0;
`ifdef SR_FLAG_ERR_EN
                if (ms[g] && mr[g] && !merr) begin
                    merr     = 1'b1;
                    merr_req = g;
                end
`endif
                mptr       = (g + 1) % NREQ;
                pend[g]    = 1'b0;
                bus.req[g] = 1'b0;
                tick();
                n_checks++;
                if (bus.flags !== mflags || bus.flags_b !== ~mflags || bus.ack !== '0) begin
                    n_fail++;
                    $display("FAIL rand_flags round=%0d: flags=%h flags_b=%h ack=%b want %h/%h/0",
                             round, bus.flags, bus.flags_b, bus.ack, mflags, ~mflags);
                end
`ifdef SR_FLAG_ERR_EN
                n_checks++;
                if (bus.err !== merr || (merr && int'(bus.err_req) != merr_req)) begin
                    n_fail++;
                    $display("FAIL rand_err round=%0d: err=%b err_req=%0d want %b/%0d",
                             round, bus.err, bus.err_req, merr, merr_req);
                end
`endif
            end
        end
    endtask

    initial begin
        clear       = 1'b1;
        bus.req     = '0;
        bus.cmd_s   = '0;
        bus.cmd_r   = '0;
        bus.cmd_idx = '0;
        test_reset();
        test_single();
        test_three();
        test_same_idx();
        test_both();
        test_clear_apply();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
